// File: rtl/parking_controller_p_if.sv
// Bus between the gate sensors and the lot display/billing side of the
// parking controller. The controller binds the slave modport; whatever drives
// the sensors and consumes the outputs binds the master modport.
//
// Handshake semantics: there is no valid/ready pair. car_enter / car_leave are
// level sensors, and each rising edge is one request. Every request is either
// accepted (a gate opens and the counters move) or rejected (entry_denied or
// exit_error pulses for exactly one cycle). Nothing is queued or retried.
interface parking_controller_p_if #(
    parameter int CNT_W    = 4,
    parameter int PROFIT_W = 8
);
    logic                car_enter;
    logic                car_leave;
    logic [CNT_W-1:0]    occupied;
    logic [CNT_W-1:0]    free_slots;
    logic                full;
    logic                empty;
    logic [PROFIT_W-1:0] profit;
    logic                gate_in_open;
    logic                gate_out_open;
    logic                entry_denied;
    logic                exit_error;
    logic [6:0]          seven_seg;
    // Debug view of the two gate FSM state registers (0 = IDLE, 1 = OPEN).
    logic                entry_state;
    logic                exit_state;

    modport slave (
        input  car_enter, car_leave,
        output occupied, free_slots, full, empty, profit,
               gate_in_open, gate_out_open, entry_denied, exit_error,
               seven_seg, entry_state, exit_state
    );

    modport master (
        output car_enter, car_leave,
        input  occupied, free_slots, full, empty, profit,
               gate_in_open, gate_out_open, entry_denied, exit_error,
               seven_seg, entry_state, exit_state
    );
endinterface

// File: rtl/parking_controller_p.sv
// Parametrised parking-lot controller: occupancy tracking, timed entry/exit
// gates, a saturating fee accumulator and a hex display of free slots.
module parking_controller_p #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int FEE         = 2,
    parameter int PROFIT_W    = 8,
    parameter int GATE_CYCLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    parking_controller_p_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    localparam int                  TMR_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0]    TMR_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CAP        = CNT_W'(CAPACITY);
    localparam logic [PROFIT_W-1:0] PROFIT_MAX = '1;
    localparam logic [PROFIT_W:0]   FEE_EXT    = (PROFIT_W + 1)'(FEE);

    logic                enter_q, leave_q, armed;
    logic [CNT_W-1:0]    occupied;
    logic [PROFIT_W-1:0] profit;
    logic [0:0]          in_state, out_state;
    logic [TMR_W-1:0]    in_timer, out_timer;
    logic                entry_denied, exit_error;

    logic                enter_rise, leave_rise;
    logic                full, empty;
    logic                acc_in, acc_out;
    logic [PROFIT_W:0]   profit_sum;
    logic [CNT_W-1:0]    free_slots;
    logic [3:0]          digit;
    logic [6:0]          seg;

    // Sensor history for edge detection. armed is low only on the first cycle
    // after reset release, so a sensor already high at release (whose _q was
    // cleared by reset) is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_q <= 1'b0;
            leave_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            enter_q <= bus.car_enter;
            leave_q <= bus.car_leave;
            armed   <= 1'b1;
        end
    end

    assign enter_rise = armed & bus.car_enter & ~enter_q;
    assign leave_rise = armed & bus.car_leave & ~leave_q;
    assign full       = (occupied == CAP);
    assign empty      = (occupied == '0);

    // Exit is decided first so that a simultaneous departure can make room
    // for an arrival at a full lot.
    assign acc_out    = leave_rise & ~empty & (out_state == ST_IDLE);
    assign acc_in     = enter_rise & (in_state == ST_IDLE) & (~full | acc_out);
    assign profit_sum = {1'b0, profit} + FEE_EXT;

    // Occupancy, fee total and the registered reject pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupied     <= '0;
            profit       <= '0;
            entry_denied <= 1'b0;
            exit_error   <= 1'b0;
        end else begin
            occupied     <= occupied + CNT_W'(acc_in) - CNT_W'(acc_out);
            entry_denied <= enter_rise & ~acc_in;
            exit_error   <= leave_rise & ~acc_out;
            if (acc_out) begin
                profit <= profit_sum[PROFIT_W] ? PROFIT_MAX : profit_sum[PROFIT_W-1:0];
            end
        end
    end

    // Entry gate: opens on an accepted arrival and stays open GATE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state <= ST_IDLE;
            in_timer <= '0;
        end else if (in_state == ST_IDLE) begin
            if (acc_in) begin
                in_state <= ST_OPEN;
                in_timer <= TMR_LOAD;
            end
        end else if (in_timer == '0) begin
            in_state <= ST_IDLE;
        end else begin
            in_timer <= in_timer - TMR_W'(1);
        end
    end

    // Exit gate: same timing as the entry gate, triggered by accepted departures.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state <= ST_IDLE;
            out_timer <= '0;
        end else if (out_state == ST_IDLE) begin
            if (acc_out) begin
                out_state <= ST_OPEN;
                out_timer <= TMR_LOAD;
            end
        end else if (out_timer == '0) begin
            out_state <= ST_IDLE;
        end else begin
            out_timer <= out_timer - TMR_W'(1);
        end
    end

    assign free_slots = CAP - occupied;
    assign digit      = 4'(free_slots);

    // Hex digit of free slots, segments {g,f,e,d,c,b,a}, active high.
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign bus.occupied      = occupied;
    assign bus.free_slots    = free_slots;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.profit        = profit;
    assign bus.gate_in_open  = (in_state == ST_OPEN);
    assign bus.gate_out_open = (out_state == ST_OPEN);
    assign bus.entry_denied  = entry_denied;
    assign bus.exit_error    = exit_error;
    assign bus.seven_seg     = seg;
    assign bus.entry_state   = in_state[0];
    assign bus.exit_state    = out_state[0];
endmodule

// File: tb/tb_parking_controller_p.sv
// Directed bench for parking_controller_p: a default-sized lot plus a second
// instance with a 3-bit fee total to exercise saturation.
module tb_parking_controller_p;
    logic clk = 1'b0;
    logic reset;

    logic [15:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cnt;
    int          sat_exp[5] = '{2, 4, 6, 7, 7};

    // Clock / DUT block
    always #5 clk = ~clk;

    parking_controller_p_if #(.CNT_W(4), .PROFIT_W(8)) bus ();
    parking_controller_p_if #(.CNT_W(4), .PROFIT_W(3)) bus_s ();

    parking_controller_p #(
        .CAPACITY(8), .CNT_W(4), .FEE(2), .PROFIT_W(8), .GATE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    parking_controller_p #(
        .CAPACITY(8), .CNT_W(4), .FEE(2), .PROFIT_W(3), .GATE_CYCLES(4)
    ) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    // Scoreboard: pop the oldest expectation and compare.
    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %0h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic enter_main();
        bus.car_enter = 1'b1;
        tick(1);
        bus.car_enter = 1'b0;
    endtask

    task automatic leave_main();
        bus.car_leave = 1'b1;
        tick(1);
        bus.car_leave = 1'b0;
    endtask

    task automatic count_gate(input bit out_gate, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            c += out_gate ? int'(bus.gate_out_open) : int'(bus.gate_in_open);
            tick(1);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.car_enter   = 1'b0;
        bus.car_leave   = 1'b0;
        bus_s.car_enter = 1'b0;
        bus_s.car_leave = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(5);

        // Reset state after release and idle cycles
        push(16'd0); push(16'd8); push(16'd1); push(16'd0); push(16'd0);
        push(16'h7F); push(16'd0); push(16'd0); push(16'd0); push(16'd0);
        check("rst_occupied",   16'(bus.occupied));
        check("rst_free",       16'(bus.free_slots));
        check("rst_empty",      16'(bus.empty));
        check("rst_full",       16'(bus.full));
        check("rst_profit",     16'(bus.profit));
        check("rst_seg",        16'(bus.seven_seg));
        check("rst_gate_in",    16'(bus.gate_in_open));
        check("rst_gate_out",   16'(bus.gate_out_open));
        check("rst_denied",     16'(bus.entry_denied));
        check("rst_exit_error", 16'(bus.exit_error));

        // Saturating fee total on the 3-bit instance
        for (int k = 0; k < 5; k++) begin
            bus_s.car_enter = 1'b1;
            tick(1);
            bus_s.car_enter = 1'b0;
            tick(6);
        end
        for (int k = 0; k < 5; k++) begin
            bus_s.car_leave = 1'b1;
            push(16'(sat_exp[k]));
            tick(1);
            bus_s.car_leave = 1'b0;
            check("sat_profit", 16'(bus_s.profit));
            tick(6);
        end

        // Two spaced entries, each gate open exactly 4 cycles
        for (int k = 0; k < 2; k++) begin
            enter_main();
            push(16'(k + 1));
            check("entry_occupied", 16'(bus.occupied));
            push(16'd4);
            count_gate(1'b0, 8, cnt);
            check("gate_in_width", 16'(cnt));
            tick(2);
        end
        push(16'd6); push(16'h7D);
        check("two_free", 16'(bus.free_slots));
        check("two_seg",  16'(bus.seven_seg));

        // Fill the lot
        for (int k = 2; k < 8; k++) begin
            enter_main();
            tick(6);
        end
        push(16'd8); push(16'd1); push(16'd0); push(16'h3F); push(16'd0);
        check("fill_occupied", 16'(bus.occupied));
        check("fill_full",     16'(bus.full));
        check("fill_free",     16'(bus.free_slots));
        check("fill_seg",      16'(bus.seven_seg));
        check("fill_empty",    16'(bus.empty));

        // Arrival at a full lot is denied for one cycle
        enter_main();
        push(16'd1); push(16'd8); push(16'd0);
        check("full_denied",   16'(bus.entry_denied));
        check("full_occupied", 16'(bus.occupied));
        check("full_gate_in",  16'(bus.gate_in_open));
        tick(1);
        push(16'd0);
        check("full_denied_end", 16'(bus.entry_denied));
        tick(4);

        // Simultaneous arrival and departure at full
        bus.car_enter = 1'b1;
        bus.car_leave = 1'b1;
        tick(1);
        bus.car_enter = 1'b0;
        bus.car_leave = 1'b0;
        push(16'd8); push(16'd2); push(16'd1); push(16'd1); push(16'd0); push(16'd0);
        check("swap_occupied", 16'(bus.occupied));
        check("swap_profit",   16'(bus.profit));
        check("swap_gate_in",  16'(bus.gate_in_open));
        check("swap_gate_out", 16'(bus.gate_out_open));
        check("swap_denied",   16'(bus.entry_denied));
        check("swap_error",    16'(bus.exit_error));
        tick(6);

        // Departure, then a second departure while the exit gate is open
        leave_main();
        push(16'd7); push(16'd4);
        check("leave1_occupied", 16'(bus.occupied));
        check("leave1_profit",   16'(bus.profit));
        tick(1);
        leave_main();
        push(16'd1); push(16'd7); push(16'd4);
        check("busy_exit_error", 16'(bus.exit_error));
        check("busy_occupied",   16'(bus.occupied));
        check("busy_profit",     16'(bus.profit));
        tick(6);
        leave_main();
        push(16'd6); push(16'd6);
        check("leave2_occupied", 16'(bus.occupied));
        check("leave2_profit",   16'(bus.profit));
        tick(6);

        // Second arrival while the entry gate is still open
        enter_main();
        push(16'd7); push(16'd1);
        check("open_occupied",   16'(bus.occupied));
        check("open_state_dbg",  16'(bus.entry_state));
        tick(1);
        enter_main();
        push(16'd1); push(16'd7);
        check("open_denied",     16'(bus.entry_denied));
        check("open_occ_once",   16'(bus.occupied));
        tick(6);

        // Drain, then a departure from an empty lot
        for (int k = 0; k < 7; k++) begin
            leave_main();
            tick(6);
        end
        push(16'd0); push(16'd20); push(16'd1); push(16'd8); push(16'h7F);
        check("drain_occupied", 16'(bus.occupied));
        check("drain_profit",   16'(bus.profit));
        check("drain_empty",    16'(bus.empty));
        check("drain_free",     16'(bus.free_slots));
        check("drain_seg",      16'(bus.seven_seg));
        leave_main();
        push(16'd1); push(16'd20); push(16'd0); push(16'd0);
        check("empty_exit_error", 16'(bus.exit_error));
        check("empty_profit",     16'(bus.profit));
        check("empty_occupied",   16'(bus.occupied));
        check("empty_gate_out",   16'(bus.gate_out_open));
        tick(3);

        // Reset with the exit gate open and three cars parked
        for (int k = 0; k < 4; k++) begin
            enter_main();
            tick(6);
        end
        leave_main();
        push(16'd3); push(16'd1);
        check("pre_rst_occupied", 16'(bus.occupied));
        check("pre_rst_gate_out", 16'(bus.gate_out_open));
        reset = 1'b0;
        bus.car_enter = 1'b1;
        #1;
        push(16'd0); push(16'd0); push(16'd0); push(16'd8); push(16'h7F);
        push(16'd1); push(16'd0);
        check("mid_rst_gate_out", 16'(bus.gate_out_open));
        check("mid_rst_occupied", 16'(bus.occupied));
        check("mid_rst_profit",   16'(bus.profit));
        check("mid_rst_free",     16'(bus.free_slots));
        check("mid_rst_seg",      16'(bus.seven_seg));
        check("mid_rst_empty",    16'(bus.empty));
        check("mid_rst_gate_in",  16'(bus.gate_in_open));
        tick(2);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            cnt += int'(bus.gate_in_open) + int'(bus.entry_denied);
        end
        push(16'd0); push(16'd0);
        check("held_sensor_events",   16'(cnt));
        check("held_sensor_occupied", 16'(bus.occupied));
        bus.car_enter = 1'b0;
        tick(2);
        enter_main();
        push(16'd1);
        check("post_rst_entry", 16'(bus.occupied));
        tick(6);

        // Every queued expectation must have been consumed
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_controller_p.md
Name: parking_controller_p

Overview:
- Parametrised successor to the single-lot parking system.
- Tracks occupancy up to a configurable CAPACITY and drives timed entry and exit gate FSMs.
- Accumulates a saturating fee total charged per exit, flags denied entries and invalid exits, and drives a 7-segment hex display of free slots.
- Sits between the gate sensors (car_enter/car_leave) and the lot display/billing logic.

Parameters:
- CAPACITY, 8, number of slots; legal range 1..15.
- CNT_W, 4, width of occupancy/free counters; must hold CAPACITY.
- FEE, 2, amount added to profit on each accepted exit.
- PROFIT_W, 8, profit accumulator width.
- GATE_CYCLES, 4, cycles a gate stays open after an accepted event; must be >=1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- car_enter  in  1  entry sensor level; a rising edge is one arrival request.
- car_leave  in  1  exit sensor level; a rising edge is one departure request.
- occupied  out  CNT_W  cars currently parked.
- free_slots  out  CNT_W  CAPACITY - occupied.
- full  out  1  occupied == CAPACITY.
- empty  out  1  occupied == 0.
- profit  out  PROFIT_W  accumulated fees, saturating.
- gate_in_open  out  1  entry gate open.
- gate_out_open  out  1  exit gate open.
- entry_denied  out  1  one-cycle pulse: an arrival was rejected.
- exit_error  out  1  one-cycle pulse: a departure was rejected.
- seven_seg  out  7  {g,f,e,d,c,b,a}, active-high, hex digit of free_slots.

Behaviour:
- Reset (reset==0, async) values:
  - occupied=0, free_slots=CAPACITY, full=0, empty=1, profit=0.
  - Both gates closed, entry_denied=0, exit_error=0.
  - Edge-detect registers cleared to 0.
  - seven_seg = encoding of CAPACITY.
- Reset mid-operation aborts any open gate immediately. A sensor held high through reset release is not an edge.
- Edge detect: enter_rise = car_enter & ~car_enter_q; leave_rise likewise. The _q registers update every cycle.
- Exit acceptance, evaluated first: acc_out = leave_rise & ~empty & exit FSM in IDLE.
  - leave_rise when empty or exit gate open -> exit_error pulses for 1 cycle; nothing else changes.
- Entry acceptance: acc_in = enter_rise & entry FSM in IDLE & (~full | acc_out).
  - A simultaneous exit frees the slot in the same cycle, so a full lot still admits the car.
  - Otherwise an enter_rise causes entry_denied to pulse for 1 cycle.
- Count update: occupied_next = occupied + acc_in - acc_out. It never leaves 0..CAPACITY.
  - free_slots, full, empty and seven_seg are derived from the registered occupied count.
  - They change on the edge that samples the accepted event (latency 1 cycle from the sensor rise).
- Profit: on acc_out, profit_next = min(profit + FEE, 2^PROFIT_W - 1). No wrap-around.
- Gate FSMs, one per gate, identical:
  - States IDLE, OPEN.
  - IDLE -> OPEN on accept; load timer = GATE_CYCLES - 1.
  - In OPEN, decrement timer each cycle; at timer==0 return to IDLE.
  - gate_*_open = (state==OPEN); it is high for exactly GATE_CYCLES cycles.
  - A new rise while OPEN is rejected, not queued.
- Seven-segment encoding (hex 0..F):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- The denied/error pulses are registered, so they appear the cycle after the rise is sampled.

Test Plan:
- Reset release, idle 5 cycles -> occupied=0, free_slots=8, empty=1, full=0, profit=0, seven_seg=7F.
- Two entries spaced 10 cycles apart -> occupied=2, free_slots=6, seven_seg=7D. Each entry gives gate_in_open high for exactly 4 cycles.
- Fill to 8, then another enter rise -> full=1, entry_denied pulses once, occupied stays 8. A simultaneous enter+leave at full -> occupied stays 8, profit +2, both gates open.
- Enter rise again 2 cycles after an accepted entry (gate open) -> entry_denied pulses, occupied increments only once. Leave rise with empty=1 -> exit_error pulses, profit unchanged.
- PROFIT_W=3, FEE=2, 5 accepted exits -> profit sequence 2,4,6,7,7 (saturates at 7, no wrap).
- Assert reset with the exit gate open and occupied=3 -> gate_out_open drops immediately, all outputs at reset values. Sensor held high across release produces no accept.
